// File: rtl/rec_pkg.sv
`default_nettype none
// ============================================================================
// Module : rec_pkg
// Desc   : Shared sizing and FSM state encoding for the note recorder.
// Rev    : 1.0 - initial release
// ============================================================================
package rec_pkg;

    localparam int NOTE_WIDTH = 6;
    localparam int LEN_WIDTH  = 10;
    localparam int DATA_WIDTH = NOTE_WIDTH + LEN_WIDTH;
    localparam int MAX_WORDS  = 1024;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_REC   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_FLUSH = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_SAVE  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DROP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rec_run_encoder.sv
`default_nettype none
// ============================================================================
// Module : rec_run_encoder
// Desc   : Tracks the current note and its run length; flags when a
//          {note, length} word must be emitted.
// Rev    : 1.0 - initial release
// ============================================================================
module rec_run_encoder
    import rec_pkg::*;
#(
    parameter int NOTE_WIDTH = rec_pkg::NOTE_WIDTH,
    parameter int LEN_WIDTH  = rec_pkg::LEN_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_load,
    input  logic                            i_sample,
    input  logic                            i_flush,
    input  logic [NOTE_WIDTH-1:0]           i_key,
    output logic                            o_emit,
    output logic [NOTE_WIDTH+LEN_WIDTH-1:0] o_word,
    output logic                            o_run_active
);

    localparam logic [LEN_WIDTH-1:0] c_LEN_MAX = '1;

    logic [NOTE_WIDTH-1:0] r_cur_note;
    logic [LEN_WIDTH-1:0]  r_run_len;
    logic                  w_extend;

    // A saturated run is closed even if the key is unchanged.
    assign w_extend     = (i_key == r_cur_note) && (r_run_len != c_LEN_MAX);
    assign o_run_active = (r_run_len != '0);
    assign o_word       = {r_cur_note, r_run_len};
    assign o_emit       = o_run_active && ((i_sample && !w_extend) || i_flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_note <= '0;
            r_run_len  <= '0;
        end else if (i_load) begin
            r_cur_note <= i_key;
            r_run_len  <= '0;
        end else if (i_sample) begin
            if (w_extend) begin
                r_run_len <= r_run_len + 1'b1;
            end else begin
                r_cur_note <= i_key;
                r_run_len  <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end
        end else if (i_flush) begin
            r_run_len <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
// Module : note_recorder
// Desc   : Records keyboard notes as run-length words and drives the memory
//          block's write / save / discard strobes.
// Rev    : 1.0 - initial release
// ============================================================================
module note_recorder
    import rec_pkg::*;
#(
    parameter int NOTE_WIDTH = rec_pkg::NOTE_WIDTH,
    parameter int LEN_WIDTH  = rec_pkg::LEN_WIDTH,
    parameter int DATA_WIDTH = rec_pkg::DATA_WIDTH,
    parameter int MAX_WORDS  = rec_pkg::MAX_WORDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [NOTE_WIDTH-1:0]        key_in,
    input  logic                         rec_start,
    input  logic                         rec_stop,
    input  logic                         rec_cancel,
    output logic                         write_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         save,
    output logic                         discard,
    output logic                         busy,
    output logic [$clog2(MAX_WORDS):0]   word_count
);

    localparam int                c_WC_W    = $clog2(MAX_WORDS) + 1;
    localparam logic [c_WC_W-1:0] c_WC_FULL = c_WC_W'(MAX_WORDS);

    logic [c_STATE_W-1:0]         r_state;
    logic                         w_load;
    logic                         w_full;
    logic                         w_sample;
    logic                         w_flush;
    logic                         w_emit;
    logic                         w_run_active;
    logic [DATA_WIDTH-1:0]        w_word;

    // Priority: cancel > auto-commit > stop > tick.
    assign w_load   = (r_state == c_ST_IDLE) && rec_start;
    assign w_full   = (word_count == c_WC_FULL);
    assign w_sample = (r_state == c_ST_REC) && tick && !rec_cancel && !w_full && !rec_stop;
    assign w_flush  = (r_state == c_ST_FLUSH) && !rec_cancel;

    rec_run_encoder #(
        .NOTE_WIDTH (NOTE_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_run_encoder (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_sample     (w_sample),
        .i_flush      (w_flush),
        .i_key        (key_in),
        .o_emit       (w_emit),
        .o_word       (w_word),
        .o_run_active (w_run_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            write_en   <= 1'b0;
            data_out   <= '0;
            save       <= 1'b0;
            discard    <= 1'b0;
            busy       <= 1'b0;
            word_count <= '0;
        end else begin
            write_en <= 1'b0;
            save     <= 1'b0;
            discard  <= 1'b0;

            if (w_emit) begin
                write_en   <= 1'b1;
                data_out   <= w_word;
                word_count <= word_count + 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (rec_start) begin
                        r_state    <= c_ST_REC;
                        busy       <= 1'b1;
                        word_count <= '0;
                    end
                end
                c_ST_REC: begin
                    if (rec_cancel) begin
                        r_state <= c_ST_DROP;
                        discard <= 1'b1;
                    end else if (w_full) begin
                        r_state <= c_ST_SAVE;
                        save    <= 1'b1;
                    end else if (rec_stop) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    // The final word goes out first; commit/abandon follows next cycle.
                    if (rec_cancel) begin
                        r_state <= c_ST_DROP;
                        discard <= 1'b1;
                    end else if (!w_run_active) begin
                        if (word_count == '0) begin
                            r_state <= c_ST_DROP;
                            discard <= 1'b1;
                        end else begin
                            r_state <= c_ST_SAVE;
                            save    <= 1'b1;
                        end
                    end
                end
                c_ST_SAVE, c_ST_DROP: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
// Module : tb_note_recorder
// Desc   : Self-checking bench for note_recorder against a run-length model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_note_recorder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        rec_start = 1'b0;
    logic        rec_stop = 1'b0;
    logic        rec_cancel = 1'b0;
    logic [5:0]  key_in = '0;

    logic        write_en, save, discard, busy;
    logic [15:0] data_out;
    logic [10:0] word_count;
    logic        write_en4, save4, discard4, busy4;
    logic [15:0] data_out4;
    logic [2:0]  word_count4;

    always #5 clk = ~clk;

    note_recorder dut (
        .clk(clk), .rst(rst), .tick(tick), .key_in(key_in),
        .rec_start(rec_start), .rec_stop(rec_stop), .rec_cancel(rec_cancel),
        .write_en(write_en), .data_out(data_out), .save(save), .discard(discard),
        .busy(busy), .word_count(word_count)
    );

    note_recorder #(.MAX_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .key_in(key_in),
        .rec_start(rec_start), .rec_stop(rec_stop), .rec_cancel(rec_cancel),
        .write_en(write_en4), .data_out(data_out4), .save(save4), .discard(discard4),
        .busy(busy4), .word_count(word_count4)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] got_q[$];
    logic [15:0] got4_q[$];
    int          save_cnt = 0, discard_cnt = 0, excl_err = 0;
    int          save4_cnt = 0, last_wr4_cyc = 0, save4_cyc = 0;
    logic        busy4_after = 1'b1;
    logic        prev_save4 = 1'b0;
    int          samples[$];
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_en) got_q.push_back(data_out);
        if (save) save_cnt <= save_cnt + 1;
        if (discard) discard_cnt <= discard_cnt + 1;
        if ((int'(write_en) + int'(save) + int'(discard) > 1) ||
            (int'(write_en4) + int'(save4) + int'(discard4) > 1))
            excl_err <= excl_err + 1;
        if (write_en4) begin
            got4_q.push_back(data_out4);
            last_wr4_cyc <= cyc;
        end
        if (save4) begin
            save4_cnt <= save4_cnt + 1;
            save4_cyc <= cyc;
        end
        if (prev_save4) busy4_after <= busy4;
        prev_save4 <= save4;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_rec(input logic [5:0] k);
        key_in = k; rec_start = 1'b1; step(); rec_start = 1'b0;
        samples.delete();
    endtask

    task automatic tick_key(input logic [5:0] k);
        key_in = k; tick = 1'b1; step(); tick = 1'b0;
        samples.push_back(int'(k));
    endtask

    task automatic stop_rec();
        rec_stop = 1'b1; step(); rec_stop = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: busy=%0b after %0d cycles, required 0", nm, busy, n);
        end
    endtask

    // Reference: the emitted stream is the plain run-length coding of the
    // sampled keys, runs split into chunks of at most 1023; the final chunk is
    // still in progress and only appears once the recording is stopped.
    task automatic build_expected(input bit drop_last, input int max_words);
        int i, k, n, c;
        exp_q.delete();
        i = 0;
        while (i < samples.size()) begin
            k = samples[i];
            n = 0;
            while (i < samples.size() && samples[i] == k) begin
                n++;
                i++;
            end
            while (n > 0) begin
                c = (n > 1023) ? 1023 : n;
                exp_q.push_back({6'(k), 10'(c)});
                n -= c;
            end
        end
        if (drop_last && exp_q.size() > 0) void'(exp_q.pop_back());
        while (exp_q.size() > max_words) void'(exp_q.pop_back());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if ({write_en, save, discard, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b, required 0000", {write_en, save, discard, busy});
        end
        vectors++;
        if (data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data: got %h, required 0000", data_out);
        end
        vectors++;
        if (word_count !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d, required 0", word_count);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int bq, bs, bd;
        logic [15:0] w0, w1;
        bq = got_q.size(); bs = save_cnt; bd = discard_cnt;
        start_rec(6'd5);
        repeat (3) tick_key(6'd5);
        repeat (2) tick_key(6'd7);
        stop_rec();
        wait_idle("basic_idle");
        step();
        w0 = (got_q.size() > bq) ? got_q[bq] : 16'hxxxx;
        w1 = (got_q.size() > bq + 1) ? got_q[bq + 1] : 16'hxxxx;
        vectors++;
        if (got_q.size() - bq != 2) begin
            miscompares++;
            $display("FAIL basic_nwords: got %0d, required 2", got_q.size() - bq);
        end
        vectors++;
        if (w0 !== 16'h1403) begin
            miscompares++;
            $display("FAIL basic_word0: got %h, required 1403", w0);
        end
        vectors++;
        if (w1 !== 16'h1C02) begin
            miscompares++;
            $display("FAIL basic_word1: got %h, required 1c02", w1);
        end
        vectors++;
        if (save_cnt - bs != 1 || discard_cnt - bd != 0) begin
            miscompares++;
            $display("FAIL basic_pulses: save %0d discard %0d, required 1 0", save_cnt - bs, discard_cnt - bd);
        end
        vectors++;
        if (word_count !== 11'd2) begin
            miscompares++;
            $display("FAIL basic_count: got %0d, required 2", word_count);
        end
    endtask

    task automatic test_long_run();
        int bq, bs;
        logic [15:0] w0, w1;
        bq = got_q.size(); bs = save_cnt;
        start_rec(6'd3);
        repeat (1025) tick_key(6'd3);
        stop_rec();
        wait_idle("long_idle");
        step();
        w0 = (got_q.size() > bq) ? got_q[bq] : 16'hxxxx;
        w1 = (got_q.size() > bq + 1) ? got_q[bq + 1] : 16'hxxxx;
        vectors++;
        if (got_q.size() - bq != 2 || w0 !== 16'h0FFF || w1 !== 16'h0C02) begin
            miscompares++;
            $display("FAIL long_words: got n=%0d %h %h, required n=2 0fff 0c02", got_q.size() - bq, w0, w1);
        end
        vectors++;
        if (save_cnt - bs != 1) begin
            miscompares++;
            $display("FAIL long_save: got %0d, required 1", save_cnt - bs);
        end
    endtask

    task automatic test_empty();
        int bq, bs, bd;
        bq = got_q.size(); bs = save_cnt; bd = discard_cnt;
        start_rec(6'd9);
        stop_rec();
        wait_idle("empty_idle");
        step();
        vectors++;
        if (got_q.size() != bq) begin
            miscompares++;
            $display("FAIL empty_writes: got %0d, required 0", got_q.size() - bq);
        end
        vectors++;
        if (discard_cnt - bd != 1 || save_cnt - bs != 0) begin
            miscompares++;
            $display("FAIL empty_pulses: discard %0d save %0d, required 1 0", discard_cnt - bd, save_cnt - bs);
        end
        vectors++;
        if (word_count !== 11'd0) begin
            miscompares++;
            $display("FAIL empty_count: got %0d, required 0", word_count);
        end
    endtask

    task automatic test_cancel();
        int bq, bs, bd;
        bq = got_q.size(); bs = save_cnt; bd = discard_cnt;
        start_rec(6'd0);
        tick_key(6'd1); tick_key(6'd2); tick_key(6'd3);
        step();
        rec_cancel = 1'b1; tick = 1'b1; key_in = 6'd4;
        step();
        rec_cancel = 1'b0; tick = 1'b0;
        wait_idle("cancel_idle");
        repeat (2) step();
        vectors++;
        if (got_q.size() - bq != 2) begin
            miscompares++;
            $display("FAIL cancel_writes: got %0d, required 2", got_q.size() - bq);
        end
        vectors++;
        if (discard_cnt - bd != 1 || save_cnt - bs != 0) begin
            miscompares++;
            $display("FAIL cancel_pulses: discard %0d save %0d, required 1 0", discard_cnt - bd, save_cnt - bs);
        end
    endtask

    task automatic test_random();
        int bq, bs, bd, n, mode;
        bit ok_save;
        logic [15:0] g;
        for (int it = 0; it < 30; it++) begin
            bq = got_q.size(); bs = save_cnt; bd = discard_cnt;
            start_rec(6'($urandom_range(0, 3)));
            n = $urandom_range(0, 12);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) step();
                tick_key(6'($urandom_range(0, 3)));
            end
            mode = $urandom_range(0, 2);
            key_in = 6'($urandom_range(0, 3));
            if (mode == 2) begin
                rec_cancel = 1'b1;
                tick = 1'($urandom_range(0, 1));
            end else begin
                rec_stop = 1'b1;
                tick = (mode == 1);
            end
            step();
            rec_cancel = 1'b0; rec_stop = 1'b0; tick = 1'b0;
            wait_idle("rand_idle");
            step();
            build_expected(mode == 2, 1024);
            ok_save = (mode != 2) && (exp_q.size() > 0);
            vectors++;
            if (got_q.size() - bq != exp_q.size()) begin
                miscompares++;
                $display("FAIL rand_nwords[%0d]: got %0d, required %0d", it, got_q.size() - bq, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                g = (bq + i < got_q.size()) ? got_q[bq + i] : 16'hxxxx;
                vectors++;
                if (g !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand_word[%0d.%0d]: got %h, required %h", it, i, g, exp_q[i]);
                end
            end
            vectors++;
            if (save_cnt - bs != int'(ok_save) || discard_cnt - bd != int'(!ok_save)) begin
                miscompares++;
                $display("FAIL rand_pulses[%0d]: save %0d discard %0d, required %0d %0d",
                         it, save_cnt - bs, discard_cnt - bd, int'(ok_save), int'(!ok_save));
            end
            vectors++;
            if (word_count !== 11'(exp_q.size())) begin
                miscompares++;
                $display("FAIL rand_count[%0d]: got %0d, required %0d", it, word_count, exp_q.size());
            end
        end
        vectors++;
        if (excl_err !== 0) begin
            miscompares++;
            $display("FAIL strobe_exclusive: got %0d overlaps, required 0", excl_err);
        end
    endtask

    task automatic test_max_words();
        int bq4, bs4;
        logic [15:0] g;
        rst = 1'b1; repeat (2) step(); rst = 1'b0; step();
        bq4 = got4_q.size(); bs4 = save4_cnt;
        start_rec(6'd0);
        for (int k = 1; k <= 8; k++) tick_key(6'(k));
        repeat (4) step();
        build_expected(1'b0, 4);
        vectors++;
        if (got4_q.size() - bq4 != 4) begin
            miscompares++;
            $display("FAIL max_nwords: got %0d, required 4", got4_q.size() - bq4);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (bq4 + i < got4_q.size()) ? got4_q[bq4 + i] : 16'hxxxx;
            vectors++;
            if (g !== exp_q[i]) begin
                miscompares++;
                $display("FAIL max_word[%0d]: got %h, required %h", i, g, exp_q[i]);
            end
        end
        vectors++;
        if (save4_cnt - bs4 != 1 || save4_cyc != last_wr4_cyc + 1) begin
            miscompares++;
            $display("FAIL max_save: saves %0d at cyc %0d, last write cyc %0d, required 1 save one cycle later",
                     save4_cnt - bs4, save4_cyc, last_wr4_cyc);
        end
        vectors++;
        if (busy4_after !== 1'b0 || word_count4 !== 3'd4) begin
            miscompares++;
            $display("FAIL max_after: busy %b count %0d, required 0 4", busy4_after, word_count4);
        end
        rec_cancel = 1'b1; step(); rec_cancel = 1'b0;
        wait_idle("max_cleanup");
    endtask

    task automatic test_reset_mid();
        int bs, bd;
        bs = save_cnt; bd = discard_cnt;
        start_rec(6'd1);
        tick_key(6'd1); tick_key(6'd2); tick_key(6'd3); tick_key(6'd4);
        rst = 1'b1; tick = 1'b1; key_in = 6'd5;
        step();
        tick = 1'b0;
        vectors++;
        if ({write_en, save, discard, busy} !== 4'b0000 || data_out !== 16'h0 || word_count !== 11'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: strobes %b data %h count %0d, required 0000 0000 0",
                     {write_en, save, discard, busy}, data_out, word_count);
        end
        rst = 1'b0;
        repeat (6) step();
        vectors++;
        if (save_cnt != bs || discard_cnt != bd || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pulses: save %0d discard %0d busy %b, required 0 0 0",
                     save_cnt - bs, discard_cnt - bd, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_run();
        test_empty();
        test_cancel();
        test_random();
        test_max_words();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
